// File: rtl/bin_to_bcd_converter_pkg.sv
// ============================================================================
// Module   : bin_to_bcd_converter_pkg
// Brief    : Shared types and constants for the binary-to-BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bin_to_bcd_converter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int          BCD_DIGITS     = 4;
    localparam int          SCRATCH_DIGITS = 5;
    localparam int          SCRATCH_W      = 20;
    localparam int          CNT_W          = 5;
    localparam logic [15:0] BCD_SAT        = 16'h9999;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// ============================================================================
// Module   : bcd_digit_adjust
// Brief    : Double-dabble digit correction: add 3 when the digit is 5 or more.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adjust (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_converter.sv
// ============================================================================
// Module   : bin_to_bcd_converter
// Brief    : Sequential double-dabble binary-to-BCD converter, one bit per
//            cycle. Define BIN2BCD_SATURATE_EN to show 9999 on overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_converter
    import bin_to_bcd_converter_pkg::*;
#(
    parameter int BIN_WIDTH = 16    // legal range 4..16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin_in,
    output logic [15:0]          bcd_out,
    output logic                 overflow,
    output logic                 busy,
    output logic                 done
);

    state_t                 state;
    state_t                 state_next;
    logic [BIN_WIDTH-1:0]   shift_reg;
    logic [SCRATCH_W-1:0]   scratch;
    logic [SCRATCH_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]       count;
    logic                   last_iter;
    logic                   result_ovf;
    logic [15:0]            result_bcd;
    logic [SCRATCH_W+BIN_WIDTH-1:0] shifted;

    generate
        for (genvar i = 0; i < SCRATCH_DIGITS; i++) begin : g_adjust
            bcd_digit_adjust u_adjust (
                .digit_in  (scratch[4*i +: 4]),
                .digit_out (scratch_adj[4*i +: 4])
            );
        end
    endgenerate

    // Correction happens before the shift, so the shift consumes the adjusted digits.
    assign shifted    = {scratch_adj, shift_reg} << 1;
    assign last_iter  = (count == CNT_W'(BIN_WIDTH - 1));
    assign result_ovf = (scratch[SCRATCH_W-1:16] != 4'd0);

`ifdef BIN2BCD_SATURATE_EN
    assign result_bcd = result_ovf ? BCD_SAT : scratch[15:0];
`else
    assign result_bcd = scratch[15:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_iter) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
            bcd_out   <= 16'h0000;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= bin_in;
                        scratch   <= '0;
                        count     <= '0;
                    end
                end
                SHIFT: begin
                    scratch   <= shifted[SCRATCH_W+BIN_WIDTH-1:BIN_WIDTH];
                    shift_reg <= shifted[BIN_WIDTH-1:0];
                    count     <= count + 1'b1;
                end
                FINISH: begin
                    overflow <= result_ovf;
                    bcd_out  <= result_bcd;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_converter.sv
// ============================================================================
// Module   : tb_bin_to_bcd_converter
// Brief    : Self-checking bench for bin_to_bcd_converter (vector table plus
//            scoreboard of expected results popped on each done pulse).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_converter;

    localparam int BIN_WIDTH = 16;
    localparam int NVEC      = 14;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin_in = 16'h0000;
    logic [15:0] bcd_out;
    logic        overflow;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    vec_t vecs[NVEC];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bin_to_bcd_converter #(.BIN_WIDTH(BIN_WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .bcd_out  (bcd_out),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_bcd(input int v);
        int r;
        r = v;
        if (r > 9999) begin
`ifdef BIN2BCD_SATURATE_EN
            return 16'h9999;
`else
            r = r % 10000;
`endif
        end
        return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    function automatic logic model_ovf(input int v);
        return v > 9999;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_bcd_out", {16'd0, bcd_out}, {16'd0, e.bcd});
                check("sb_overflow", {31'd0, overflow}, {31'd0, e.ovf});
            end
        end
    end

    task automatic push_exp(input logic [15:0] v);
        exp_t e;
        e.bcd = model_bcd(int'(v));
        e.ovf = model_ovf(int'(v));
        sb.push_back(e);
    endtask

    // Waits for done; n counts negedges after the current one (bounded).
    task automatic wait_done(input int limit, output int n, output int busy_cycles);
        n = 0;
        busy_cycles = 0;
        while (!done && n < limit) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic convert(input logic [15:0] v, output int lat, output int busy_cycles);
        @(negedge clk);
        bin_in = v;
        start  = 1'b1;
        push_exp(v);
        @(negedge clk);
        start = 1'b0;
        wait_done(40, lat, busy_cycles);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bc;
        int gap;
        int seen;

        vecs[0].bin  = 16'd1234;  vecs[1].bin  = 16'd9999;  vecs[2].bin  = 16'd0;
        vecs[3].bin  = 16'd10000; vecs[4].bin  = 16'hFFFF;  vecs[5].bin  = 16'd1;
        vecs[6].bin  = 16'd9;     vecs[7].bin  = 16'd10;    vecs[8].bin  = 16'd99;
        vecs[9].bin  = 16'd100;   vecs[10].bin = 16'd999;   vecs[11].bin = 16'd1000;
        vecs[12].bin = 16'($urandom_range(0, 9999));
        vecs[13].bin = 16'($urandom_range(10000, 65535));
        for (int i = 0; i < NVEC; i++) begin
            vecs[i].bcd = model_bcd(int'(vecs[i].bin));
            vecs[i].ovf = model_ovf(int'(vecs[i].bin));
        end

        repeat (3) @(negedge clk);
        check("reset_bcd_out", {16'd0, bcd_out}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);

        // start held through reset release is accepted at the first edge after release
        bin_in = 16'd1234;
        start  = 1'b1;
        push_exp(16'd1234);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("start_at_release_busy", {31'd0, busy}, 32'd1);
        wait_done(40, lat, bc);
        check("start_at_release_latency", lat, BIN_WIDTH + 1);

        for (int i = 0; i < NVEC; i++) begin
            convert(vecs[i].bin, lat, bc);
            check("table_bcd_out", {16'd0, bcd_out}, {16'd0, vecs[i].bcd});
            check("table_overflow", {31'd0, overflow}, {31'd0, vecs[i].ovf});
            check("table_latency", lat, BIN_WIDTH + 1);
            check("table_busy_cycles", bc, BIN_WIDTH + 1);
            check("table_busy_low_at_done", {31'd0, busy}, 32'd0);
        end

        // start pulses and bin_in changes during busy are ignored
        @(negedge clk);
        bin_in = 16'd1234;
        start  = 1'b1;
        push_exp(16'd1234);
        @(negedge clk);
        start  = 1'b0;
        bin_in = 16'd5678;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40, lat, bc);
        check("ignore_busy_bcd_out", {16'd0, bcd_out}, 32'h1234);

        // back-to-back start in the done cycle
        bin_in = 16'd5678;
        start  = 1'b1;
        push_exp(16'd5678);
        @(negedge clk);
        start = 1'b0;
        gap = 1;
        while (!done && gap < 60) begin
            @(negedge clk);
            gap++;
        end
        check("back_to_back_gap", gap, BIN_WIDTH + 2);
        check("back_to_back_bcd_out", {16'd0, bcd_out}, 32'h5678);
        repeat (3) @(negedge clk);
        check("idle_after_b2b_busy", {31'd0, busy}, 32'd0);

        // reset mid-conversion
        convert(16'd1234, lat, bc);
        @(negedge clk);
        bin_in = 16'd4321;
        start  = 1'b1;
        push_exp(16'd4321);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_bcd_out", {16'd0, bcd_out}, 32'd0);
        check("midreset_overflow", {31'd0, overflow}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no_done_after_reset", seen, 0);
        convert(16'd4321, lat, bc);
        check("restart_latency", lat, BIN_WIDTH + 1);
        check("restart_bcd_out", {16'd0, bcd_out}, 32'h4321);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
